// File: rtl/hist_acc_ram.sv
// hist_acc_ram
// Histogram bin RAM with an in-place read-modify-write increment path.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   inc_valid, inc_bin    one bin increment per cycle (accepted when inc_ready)
//   inc_ready             low while the zero sweep runs
//   clr_start, clr_busy   start / status of the sweep that zeroes every bin
//   rd_en, rd_addr        readout request (only when no increment and not busy)
//   rd_valid, rd_data     readout result, one cycle after an accepted request
//   sat_flag              sticky: an all-ones bin was incremented again
//
// The bin memory is a simple dual-port array with a registered read. A read
// that lands on the same edge as a write returns the old contents, so a
// one-entry forwarding register supplies the most recent written value for
// back-to-back hits on the same bin.
module hist_acc_ram #(
    parameter int BITWIDTH  = 16,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_valid,
    input  logic [ADDRWIDTH-1:0] inc_bin,
    output logic                 inc_ready,
    input  logic                 clr_start,
    output logic                 clr_busy,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [BITWIDTH-1:0]  rd_data,
    output logic                 sat_flag
);

    localparam int DEPTH = 2**ADDRWIDTH;
    localparam logic [BITWIDTH-1:0]  ALL_ONES   = '1;
    localparam logic [ADDRWIDTH:0]   SWEEP_LAST = (ADDRWIDTH+1)'(DEPTH-1);

    // Bin storage and its registered read data.
    logic [BITWIDTH-1:0]  mem [DEPTH];
    logic [BITWIDTH-1:0]  mem_q_reg;

    // Stage 1: the lookup issued on the previous edge.
    logic                 s1_inc_reg;
    logic                 s1_rd_reg;
    logic [ADDRWIDTH-1:0] s1_addr_reg;

    // Forwarding of the last increment write.
    logic                 fwd_valid_reg;
    logic [ADDRWIDTH-1:0] fwd_addr_reg;
    logic [BITWIDTH-1:0]  fwd_val_reg;

    logic                 sat_reg;
    logic                 clr_busy_reg;
    logic [ADDRWIDTH:0]   sweep_addr_reg;

    logic                 inc_acc;
    logic                 rd_acc;
    logic                 clr_acc;
    logic [ADDRWIDTH-1:0] raddr_next;
    logic [BITWIDTH-1:0]  old_val;
    logic                 sat_hit;
    logic [BITWIDTH-1:0]  new_val;
    logic                 inc_wr;
    logic                 we;
    logic [ADDRWIDTH-1:0] waddr;
    logic [BITWIDTH-1:0]  wdata;

    assign inc_acc = inc_valid && !clr_busy_reg;
    assign rd_acc  = rd_en && !inc_valid && !clr_busy_reg;
    assign clr_acc = clr_start && !clr_busy_reg;

    // Increments and reads never share a cycle, so one lookup address serves both.
    assign raddr_next = rd_acc ? rd_addr : inc_bin;

    // The RAM output is stale when the same bin was written on the edge that
    // captured it; the forwarding register holds that fresher value.
    assign old_val = (fwd_valid_reg && (fwd_addr_reg == s1_addr_reg)) ? fwd_val_reg : mem_q_reg;
    assign sat_hit = (old_val == ALL_ONES);
    assign new_val = sat_hit ? old_val : old_val + BITWIDTH'(1);

    // An increment accepted on the same edge as a clear would collide with the
    // first sweep write; it is dropped since the sweep zeroes that bin anyway.
    assign inc_wr = s1_inc_reg && !clr_busy_reg;

    assign we    = clr_busy_reg || inc_wr;
    assign waddr = clr_busy_reg ? sweep_addr_reg[ADDRWIDTH-1:0] : s1_addr_reg;
    assign wdata = clr_busy_reg ? '0 : new_val;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        mem_q_reg <= mem[raddr_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_inc_reg     <= 1'b0;
            s1_rd_reg      <= 1'b0;
            fwd_valid_reg  <= 1'b0;
            sat_reg        <= 1'b0;
            clr_busy_reg   <= 1'b1;
            sweep_addr_reg <= '0;
        end else begin
            s1_inc_reg <= inc_acc;
            s1_rd_reg  <= rd_acc;

            if (inc_wr) begin
                fwd_valid_reg <= 1'b1;
                if (sat_hit) begin
                    sat_reg <= 1'b1;
                end
            end

            // Clear acceptance overrides whatever the completing increment did.
            if (clr_acc) begin
                fwd_valid_reg  <= 1'b0;
                sat_reg        <= 1'b0;
                clr_busy_reg   <= 1'b1;
                sweep_addr_reg <= '0;
            end else if (clr_busy_reg) begin
                if (sweep_addr_reg == SWEEP_LAST) begin
                    clr_busy_reg <= 1'b0;
                end else begin
                    sweep_addr_reg <= sweep_addr_reg + (ADDRWIDTH+1)'(1);
                end
            end
        end
    end

    // Datapath registers without reset; their valid bits gate them.
    always_ff @(posedge clk) begin
        s1_addr_reg <= raddr_next;
        if (inc_wr) begin
            fwd_addr_reg <= s1_addr_reg;
            fwd_val_reg  <= new_val;
        end
    end

    assign inc_ready = ~clr_busy_reg;
    assign clr_busy  = clr_busy_reg;
    assign rd_valid  = s1_rd_reg;
    assign rd_data   = s1_rd_reg ? old_val : '0;
    assign sat_flag  = sat_reg;

endmodule

// File: tb/tb_hist_acc_ram.sv
// Testbench for hist_acc_ram: a 16-bit and a 4-bit instance share stimulus,
// each checked against its own saturating histogram model.
module tb_hist_acc_ram;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        inc_valid;
    logic [7:0]  inc_bin;
    logic        clr_start;
    logic        rd_en;
    logic [7:0]  rd_addr;

    logic        inc_ready, clr_busy, rd_valid, sat_flag;
    logic [15:0] rd_data;
    logic        inc_ready4, clr_busy4, rd_valid4, sat_flag4;
    logic [3:0]  rd_data4;

    always #5 clk = ~clk;

    hist_acc_ram #(.BITWIDTH(16), .ADDRWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .inc_valid(inc_valid), .inc_bin(inc_bin), .inc_ready(inc_ready),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .sat_flag(sat_flag)
    );

    hist_acc_ram #(.BITWIDTH(4), .ADDRWIDTH(8)) dut4 (
        .clk(clk), .rst(rst),
        .inc_valid(inc_valid), .inc_bin(inc_bin), .inc_ready(inc_ready4),
        .clr_start(clr_start), .clr_busy(clr_busy4),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid4), .rd_data(rd_data4),
        .sat_flag(sat_flag4)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [15:0] m16 [DEPTH];
    logic [3:0]  m4  [DEPTH];
    logic        s16, s4;
    int          busy_cnt;
    bit          exp_rv;
    logic [15:0] q16 [$];
    logic [3:0]  q4  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) begin
            m16[i] = '0;
            m4[i]  = '0;
        end
        s16 = 1'b0;
        s4  = 1'b0;
    endtask

    // One clock cycle: drive inputs, check this cycle's outputs, update the
    // model, advance to 1 time unit after the next rising edge.
    task automatic step(input bit r, input bit iv, input int ib,
                        input bit cs, input bit re, input int ra);
        bit busy_now;
        logic [15:0] e16;
        logic [3:0]  e4;
        rst       = r;
        inc_valid = iv;
        inc_bin   = 8'(ib);
        clr_start = cs;
        rd_en     = re;
        rd_addr   = 8'(ra);

        busy_now = (busy_cnt > 0);
        chk("clr_busy", clr_busy, busy_now);
        chk("clr_busy4", clr_busy4, busy_now);
        chk("inc_ready", inc_ready, !busy_now);
        chk("rd_valid", rd_valid, exp_rv);
        chk("rd_valid4", rd_valid4, exp_rv);
        if (exp_rv) begin
            e16 = q16.pop_front();
            e4  = q4.pop_front();
            chk("rd_data", rd_data, e16);
            chk("rd_data4", rd_data4, e4);
        end

        exp_rv = 1'b0;
        if (r) begin
            model_zero();
            q16.delete();
            q4.delete();
            busy_cnt = DEPTH;
        end else begin
            if (iv && !busy_now) begin
                if (m16[ib] == 16'hFFFF) s16 = 1'b1; else m16[ib] = m16[ib] + 16'd1;
                if (m4[ib] == 4'hF)      s4  = 1'b1; else m4[ib]  = m4[ib] + 4'd1;
            end
            if (re && !iv && !busy_now) begin
                q16.push_back(m16[ra]);
                q4.push_back(m4[ra]);
                exp_rv = 1'b1;
            end
            if (cs && !busy_now) begin
                model_zero();
                busy_cnt = DEPTH;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic inc(input int b);
        step(0, 1, b, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 0, 0, 0, 1, a);
    endtask

    task automatic check_sat(input string tag);
        idle(2);
        chk({tag, "_sat16"}, sat_flag, s16);
        chk({tag, "_sat4"}, sat_flag4, s4);
    endtask

    initial begin
        rst = 1'b1; inc_valid = 1'b0; inc_bin = '0; clr_start = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        model_zero();
        exp_rv   = 1'b0;
        busy_cnt = DEPTH;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 16'h0);
        chk("reset_sat", sat_flag, 1'b0);
        chk("reset_busy", clr_busy, 1'b1);

        // Reset pulse, then the full post-reset sweep and a readout of every bin.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(1);
        check_sat("after_reset");
        $display("reset sweep and zero readout done: total=%0d", total);

        // Ten back-to-back hits on one bin.
        for (int i = 0; i < 10; i++) inc(5);
        rd(5);
        idle(1);
        $display("back-to-back bin5 x10 read done");

        // Interleaved hazards on a cleared memory.
        step(0, 0, 0, 1, 0, 0);
        idle(DEPTH);
        inc(5); inc(5); inc(7); inc(5); inc(7); inc(7);
        rd(5); rd(7);
        idle(1);
        $display("interleave 5,5,7,5,7,7 read done");

        // Read of a bin incremented the cycle before.
        inc(9);
        rd(9);
        idle(1);
        $display("forwarded readout bin9 done");

        // Saturation of the 4-bit instance, then clear.
        for (int i = 0; i < 20; i++) inc(3);
        rd(3);
        check_sat("saturate");
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        check_sat("sat_cleared");
        idle(DEPTH);
        rd(3);
        idle(1);
        $display("saturation and clear done");

        // Increment then clear on the next cycle; activity during the sweep.
        inc(2);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) inc(4);
        step(0, 0, 0, 0, 1, 2);
        idle(80);
        step(0, 0, 0, 1, 0, 0);
        idle(DEPTH);
        rd(2); rd(4);
        idle(1);
        $display("clear interaction done");

        // Increment and clear accepted on the same edge.
        step(0, 1, 6, 1, 0, 0);
        idle(DEPTH);
        rd(6);
        idle(1);
        $display("same-edge inc and clear done");

        // Read arbitration: read dropped when an increment shares its cycle.
        inc(1);
        step(0, 1, 1, 0, 1, 1);
        idle(1);
        rd(1);
        idle(1);
        $display("read arbitration done");

        // Reset in the middle of a sweep restarts it from the beginning.
        step(0, 0, 0, 1, 0, 0);
        idle(50);
        step(1, 0, 0, 0, 0, 0);
        idle(DEPTH);
        rd(1);
        idle(1);
        $display("mid-sweep reset done");

        // Random increment stream with interleaved reads.
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 9) < 8) inc(int'($urandom_range(0, DEPTH - 1)));
            else rd(int'($urandom_range(0, DEPTH - 1)));
        end
        for (int i = 0; i < DEPTH; i++) rd(i);
        check_sat("random");
        $display("random stream of 10000 steps done: total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
